// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between instruction fetch (I) and load/store (D).
// One access in flight at a time; read data is routed back to the side that issued it.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   if (MEM_LAT < 1) begin : g_lat_check
      $fatal(1, "mem_port_arbiter: MEM_LAT must be >= 1");
   end

   localparam int LAT_W    = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
   localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   typedef enum logic {IDLE, WAIT} state_t;
   typedef enum logic {OWN_D, OWN_I} owner_t;

   state_t              state, state_d;
   owner_t              owner;
   logic [LAT_W-1:0]    lat_cnt;
   logic [STARVE_W-1:0] starve_cnt;
   logic                drop;
   logic                store_q;
   logic                starved;
   logic                last_wait;

   assign busy      = (state == WAIT);
   assign starved   = (starve_cnt == STARVE_W'(STARVE_MAX));
   assign last_wait = (state == WAIT) && (lat_cnt == LAT_W'(1));

   // Grants and memory strobes are gated by reset so every output reads 0 while it is held.
   always_comb begin
      state_d   = state;
      i_gnt     = 1'b0;
      d_gnt     = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      if (state == IDLE && reset) begin
         if (i_req && (!d_req || starved)) begin
            i_gnt    = 1'b1;
            mem_addr = i_addr;
            mem_re   = 1'b1;
            state_d  = WAIT;
         end else if (d_req) begin
            d_gnt     = 1'b1;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_we    = d_we;
            mem_re    = !d_we;
            state_d   = WAIT;
         end
      end else if (last_wait) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         owner      <= OWN_D;
         lat_cnt    <= '0;
         starve_cnt <= '0;
         drop       <= 1'b0;
         store_q    <= 1'b0;
         i_rvalid   <= 1'b0;
         d_rvalid   <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         state    <= state_d;
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;

         if (i_gnt || d_gnt) begin
            owner   <= i_gnt ? OWN_I : OWN_D;
            lat_cnt <= LAT_W'(MEM_LAT);
            drop    <= i_gnt && flush;
            store_q <= d_gnt && d_we;
         end

         // d_gnt together with i_req can only mean fetch lost a contested cycle.
         if (i_gnt)
            starve_cnt <= '0;
         else if (d_gnt && i_req && !starved)
            starve_cnt <= starve_cnt + 1'b1;

         if (state == WAIT) begin
            lat_cnt <= lat_cnt - 1'b1;
            if (owner == OWN_I && flush)
               drop <= 1'b1;
            if (last_wait) begin
               drop <= 1'b0;
               if (owner == OWN_D) begin
                  d_rvalid <= 1'b1;
                  if (!store_q)
                     d_rdata <= mem_rdata;
               end else if (!(drop || flush)) begin
                  i_rvalid <= 1'b1;
                  i_rdata  <= mem_rdata;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one MEM_LAT=1 instance and one MEM_LAT=3 instance.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   // MEM_LAT = 1 instance
   logic        flush = 1'b0, i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
   logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_we, mem_re, busy;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

   // MEM_LAT = 3 instance
   logic        b_flush = 1'b0, b_i_req = 1'b0, b_d_req = 1'b0, b_d_we = 1'b0;
   logic [31:0] b_i_addr = '0, b_d_addr = '0, b_d_wdata = '0, b_mem_rdata = '0;
   logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_mem_we, b_mem_re, b_busy;
   logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .busy(busy));

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
      .clk(clk), .reset(reset), .flush(b_flush),
      .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
      .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
      .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_re(b_mem_re),
      .mem_rdata(b_mem_rdata), .busy(b_busy));

   // Inputs change at the falling edge; outputs are sampled 1 time unit later.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic test_reset_state();
      #1;
      n_cmp++; if ({i_gnt, d_gnt, busy, i_rvalid, d_rvalid, mem_we, mem_re} !== 7'b0) begin
         n_bad++; $display("FAIL reset_ctrl: got %b expected 0000000", {i_gnt, d_gnt, busy, i_rvalid, d_rvalid, mem_we, mem_re}); end
      n_cmp++; if ({i_rdata, d_rdata, mem_addr, mem_wdata} !== 128'h0) begin
         n_bad++; $display("FAIL reset_data: got %h expected 0", {i_rdata, d_rdata, mem_addr, mem_wdata}); end
      cyc(); reset = 1'b1;
      cyc(); #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_lone_fetch();
      cyc(); i_req = 1'b1; i_addr = 32'h10; #1;
      n_cmp++; if ({i_gnt, d_gnt, mem_re, mem_we} !== 4'b1010) begin
         n_bad++; $display("FAIL fetch_issue: got %b expected 1010", {i_gnt, d_gnt, mem_re, mem_we}); end
      n_cmp++; if (mem_addr !== 32'h10) begin n_bad++; $display("FAIL fetch_addr: got %h expected 10", mem_addr); end
      cyc(); i_req = 1'b0; mem_rdata = 32'hCAFE; #1;
      n_cmp++; if ({busy, i_rvalid, mem_re} !== 3'b100) begin
         n_bad++; $display("FAIL fetch_wait: got %b expected 100", {busy, i_rvalid, mem_re}); end
      cyc(); mem_rdata = 32'h0; #1;
      n_cmp++; if ({i_rvalid, d_rvalid, busy} !== 3'b100) begin
         n_bad++; $display("FAIL fetch_rvalid: got %b expected 100", {i_rvalid, d_rvalid, busy}); end
      n_cmp++; if (i_rdata !== 32'hCAFE) begin n_bad++; $display("FAIL fetch_rdata: got %h expected cafe", i_rdata); end
      cyc(); #1;
      n_cmp++; if ({i_rvalid, i_rdata} !== {1'b0, 32'hCAFE}) begin
         n_bad++; $display("FAIL fetch_hold: got %b/%h expected 0/cafe", i_rvalid, i_rdata); end
   endtask

   task automatic test_store();
      cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h55; #1;
      n_cmp++; if ({d_gnt, i_gnt, mem_we, mem_re} !== 4'b1010) begin
         n_bad++; $display("FAIL store_issue: got %b expected 1010", {d_gnt, i_gnt, mem_we, mem_re}); end
      n_cmp++; if ({mem_addr, mem_wdata} !== {32'h40, 32'h55}) begin
         n_bad++; $display("FAIL store_bus: got %h/%h expected 40/55", mem_addr, mem_wdata); end
      cyc(); d_req = 1'b0; d_we = 1'b0; mem_rdata = 32'hBEEF; #1;
      n_cmp++; if ({mem_we, busy, d_rvalid} !== 3'b010) begin
         n_bad++; $display("FAIL store_wait: got %b expected 010", {mem_we, busy, d_rvalid}); end
      cyc(); mem_rdata = 32'h0; #1;
      n_cmp++; if ({d_rvalid, i_rvalid} !== 2'b10) begin
         n_bad++; $display("FAIL store_ack: got %b expected 10", {d_rvalid, i_rvalid}); end
      n_cmp++; if (d_rdata !== 32'h0) begin n_bad++; $display("FAIL store_rdata: got %h expected 0", d_rdata); end
      cyc(); #1;
      n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("FAIL store_pulse: got %b expected 0", d_rvalid); end
   endtask

   task automatic test_reset_mid_wait();
      cyc(); i_req = 1'b1; i_addr = 32'h20; #1;
      n_cmp++; if (i_gnt !== 1'b1) begin n_bad++; $display("FAIL rst_pre_gnt: got %b expected 1", i_gnt); end
      cyc(); mem_rdata = 32'h9999; d_req = 1'b1; reset = 1'b0; #1;
      n_cmp++; if ({i_gnt, d_gnt, busy, i_rvalid, d_rvalid, mem_we, mem_re} !== 7'b0) begin
         n_bad++; $display("FAIL rst_mid_ctrl: got %b expected 0000000", {i_gnt, d_gnt, busy, i_rvalid, d_rvalid, mem_we, mem_re}); end
      n_cmp++; if ({i_rdata, mem_addr} !== 64'h0) begin
         n_bad++; $display("FAIL rst_mid_data: got %h expected 0", {i_rdata, mem_addr}); end
      cyc(); i_req = 1'b0; d_req = 1'b0; mem_rdata = 32'h0; reset = 1'b1; #1;
      n_cmp++; if ({i_rvalid, d_rvalid, busy} !== 3'b000) begin
         n_bad++; $display("FAIL rst_release: got %b expected 000", {i_rvalid, d_rvalid, busy}); end
      cyc(); #1;
      n_cmp++; if ({i_rvalid, d_rvalid, busy, i_rdata} !== {3'b000, 32'h0}) begin
         n_bad++; $display("FAIL rst_after: got %b/%h expected 000/0", {i_rvalid, d_rvalid, busy}, i_rdata); end
   endtask

   task automatic test_contention();
      logic [1:0] exp_gnt;
      cyc(); reset = 1'b0;
      cyc(); reset = 1'b1;
      i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cyc(); i_req = 1'b1; d_req = 1'b1; #1;
         exp_gnt = (k % 5 == 4) ? 2'b10 : 2'b01;
         n_cmp++; if ({i_gnt, d_gnt} !== exp_gnt) begin
            n_bad++; $display("FAIL contend_gnt[%0d]: got %b expected %b", k, {i_gnt, d_gnt}, exp_gnt); end
         n_cmp++; if (mem_addr !== ((k % 5 == 4) ? 32'h100 : 32'h200)) begin
            n_bad++; $display("FAIL contend_addr[%0d]: got %h", k, mem_addr); end
         cyc(); #1;
         n_cmp++; if ({i_gnt, d_gnt, busy} !== 3'b001) begin
            n_bad++; $display("FAIL contend_wait[%0d]: got %b expected 001", k, {i_gnt, d_gnt, busy}); end
      end
      cyc(); i_req = 1'b0; d_req = 1'b0;
      cyc();
   endtask

   task automatic test_flush();
      cyc(); i_req = 1'b1; i_addr = 32'h30;
      cyc(); i_req = 1'b0; mem_rdata = 32'h1111;
      cyc(); mem_rdata = 32'h0; #1;
      n_cmp++; if ({i_rvalid, i_rdata} !== {1'b1, 32'h1111}) begin
         n_bad++; $display("FAIL flush_setup: got %b/%h expected 1/1111", i_rvalid, i_rdata); end
      cyc(); i_req = 1'b1; i_addr = 32'h34; #1;
      n_cmp++; if (i_gnt !== 1'b1) begin n_bad++; $display("FAIL flush_gnt: got %b expected 1", i_gnt); end
      cyc(); i_req = 1'b0; flush = 1'b1; mem_rdata = 32'h2222; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; #1;
      n_cmp++; if (d_gnt !== 1'b0) begin n_bad++; $display("FAIL flush_no_gnt_wait: got %b expected 0", d_gnt); end
      cyc(); flush = 1'b0; mem_rdata = 32'h0; #1;
      n_cmp++; if ({i_rvalid, i_rdata} !== {1'b0, 32'h1111}) begin
         n_bad++; $display("FAIL flush_drop: got %b/%h expected 0/1111", i_rvalid, i_rdata); end
      n_cmp++; if ({d_gnt, mem_re, mem_addr} !== {2'b11, 32'h80}) begin
         n_bad++; $display("FAIL flush_d_issue: got %b%b/%h expected 11/80", d_gnt, mem_re, mem_addr); end
      cyc(); d_req = 1'b0; mem_rdata = 32'h3333;
      cyc(); mem_rdata = 32'h0; #1;
      n_cmp++; if ({d_rvalid, i_rvalid, d_rdata} !== {2'b10, 32'h3333}) begin
         n_bad++; $display("FAIL flush_d_done: got %b%b/%h expected 10/3333", d_rvalid, i_rvalid, d_rdata); end
   endtask

   task automatic test_lat3();
      cyc(); b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h44; b_i_req = 1'b1; b_i_addr = 32'h50; #1;
      n_cmp++; if ({b_d_gnt, b_i_gnt, b_mem_re} !== 3'b101) begin
         n_bad++; $display("FAIL lat3_issue: got %b expected 101", {b_d_gnt, b_i_gnt, b_mem_re}); end
      for (int k = 1; k <= 3; k++) begin
         cyc(); b_d_req = 1'b0; b_mem_rdata = (k == 3) ? 32'h7777 : 32'h0; #1;
         n_cmp++; if ({b_busy, b_i_gnt, b_d_gnt, b_d_rvalid} !== 4'b1000) begin
            n_bad++; $display("FAIL lat3_wait[%0d]: got %b expected 1000", k, {b_busy, b_i_gnt, b_d_gnt, b_d_rvalid}); end
      end
      cyc(); b_mem_rdata = 32'h0; #1;
      n_cmp++; if ({b_d_rvalid, b_busy, b_i_gnt, b_d_rdata} !== {3'b101, 32'h7777}) begin
         n_bad++; $display("FAIL lat3_done: got %b/%h expected 101/7777", {b_d_rvalid, b_busy, b_i_gnt}, b_d_rdata); end
      n_cmp++; if (b_mem_addr !== 32'h50) begin n_bad++; $display("FAIL lat3_i_addr: got %h expected 50", b_mem_addr); end
      cyc(); b_i_req = 1'b0;
   endtask

   initial begin
      test_reset_state();
      test_lone_fetch();
      test_store();
      test_reset_mid_wait();
      test_contention();
      test_flush();
      test_lat3();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
